brick_hit_scorer: RTL
=====================

// Module: brick_hit_scorer
// PURPOSE
//  Scoring/brick-state stage directly downstream of ball_movement and upstream of ScoreProcessor.
//  Once per game step it:
//   - checks the cell the ball is about to enter and clears a brick there;
//   - accumulates a saturating 0..999 score;
//   - tracks lives and flags win / game over.
//  Its brick map feeds CombineToMatrix.
// PARAMETERS
//  POINTS_PER_BRICK  1   points added per cleared brick
//  LIVES             3   lives loaded at reset
//  SCORE_MAX         999 saturation ceiling of score
// PORTS
//  clock          in  1   system clock
//  reset          in  1   synchronous, active-low reset
//  step           in  1   one-cycle game-step strobe (2 Hz tick rate)
//  miss           in  1   one-cycle strobe: ball passed the plate
//  plate_hit      in  1   one-cycle strobe: ball bounced off the plate
//  Ball_rowIndex  in  4   ball row, 0 = top
//  Ball_colIndex  in  4   ball column; cells 0..7 valid
//  Ball_direction in  4   {up, down, left, right}; one vertical bit plus at most one horizontal bit
//  bricks         out 56  brick map; bit row*8+col; rows 0..6
//  score          out 10  running score, 0..SCORE_MAX
//  lives          out 2   remaining lives
//  hit            out 1   one-cycle pulse when a brick is cleared
//  busy           out 1   high while not in IDLE
//  IsGameOver     out 1   sticky: lives reached 0
//  IsWin          out 1   sticky: all 56 bricks cleared
// BEHAVIOUR
//  Reset (reset==0 at a clock edge) puts every output in its reset state:
//   - bricks = all ones; score = 0; lives = LIVES.
//   - hit, busy, IsGameOver, IsWin = 0; FSM goes to IDLE.
//   - Reset takes effect mid-operation as well; any in-flight step is dropped.
//  FSM states: IDLE -> CHECK -> UPDATE -> IDLE; DONE is terminal.
//  IDLE:
//   - miss=1: lives decrements; if the result is 0, IsGameOver=1 and go to DONE.
//     miss has priority; a step in the same cycle is dropped.
//   - Otherwise step=1 latches row/col/dir and goes to CHECK.
//  CHECK: computes the target cell.
//   - tr = row-1 if up, row+1 if down.
//   - tc = col-1 if left, col+1 if right, else col.
//   - Underflow or overflow of either index, tr > 6, or tc > 7 means no brick there.
//  UPDATE:
//   - If the target brick bit is 1: clear it, add points to score, pulse hit for exactly 1 cycle.
//   - Score addition saturates at SCORE_MAX. It never wraps.
//   - If bricks becomes all zeros in this cycle: IsWin=1 and go to DONE. Otherwise go to IDLE.
//  Latency: hit is asserted 2 cycles after the cycle that sampled step.
//   busy=1 during CHECK and UPDATE. Steps arriving while busy=1 are ignored (not queued).
//  DONE:
//   - All inputs are ignored and all outputs hold.
//   - busy=0.
//   - Only reset exits DONE.
//  plate_hit is used only by the optional combo feature and is otherwise ignored.
//  A miss strobe outside IDLE is held in a 1-bit pending flag. It is applied on the next IDLE cycle.
// CONFIGURATION
//  COMBO_BONUS_EN defined:
//   - A 3-bit combo counter increments on each hit and saturates at 7.
//   - plate_hit, miss and reset clear the counter to 0.
//   - Points per hit = POINTS_PER_BRICK * (combo value before increment + 1). Score still saturates.
//  COMBO_BONUS_EN undefined:
//   - There is no combo counter; every hit adds POINTS_PER_BRICK.
//   - plate_hit is unused.
// TESTING
//  1. Reset, ball (3,2) dir up, step:
//     -> 2 cycles later hit=1, bricks[2*8+2]=0, score=1, busy back to 0.
//  2. Ball (8,4) dir up+right, step:
//     -> target (7,5) is outside the brick area; no hit; score unchanged.
//     Ball (0,7) dir up+right -> no hit (index overflow).
//  3. Three miss strobes:
//     -> lives 3,2,1,0; IsGameOver=1 on the third.
//     A later step -> no change; a miss and step in the same cycle -> step dropped.
//  4. Preload score near 999 via repeated hits with POINTS_PER_BRICK=100:
//     -> score reaches 999 and stays there.
//     Clearing the last brick -> IsWin=1 and the block enters DONE.
//  5. reset asserted during CHECK:
//     -> next cycle bricks=all ones, score=0, hit=0, busy=0.
//  6. COMBO_BONUS_EN, four consecutive hits, then plate_hit, then a hit:
//     -> score deltas 1,2,3,4, then 1.

Source files
------------

// File: rtl/brick_hit_scorer.sv
// Brick-state and scoring stage: clears the brick the ball enters and tracks score, lives, win and game over.
// Optional COMBO_BONUS_EN macro scales points by a consecutive-hit combo counter.
module brick_hit_scorer #(
   parameter int POINTS_PER_BRICK = 1,
   parameter int LIVES            = 3,
   parameter int SCORE_MAX        = 999
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        step,
   input  logic        miss,
   input  logic        plate_hit,
   input  logic [3:0]  Ball_rowIndex,
   input  logic [3:0]  Ball_colIndex,
   input  logic [3:0]  Ball_direction,
   output logic [55:0] bricks,
   output logic [9:0]  score,
   output logic [1:0]  lives,
   output logic        hit,
   output logic        busy,
   output logic        IsGameOver,
   output logic        IsWin
);

   typedef enum logic [1:0] {IDLE, CHECK, UPDATE, DONE} state_t;

   state_t      state;
   logic [3:0]  row_q, col_q, dir_q;
   logic [5:0]  tgt_idx;
   logic        tgt_ok;
   logic        miss_pend;
   logic [4:0]  tr, tc;
   logic [31:0] pts, sum;
   logic [9:0]  score_nx;
   logic [55:0] bricks_nx;
   logic        brick_there;

`ifdef COMBO_BONUS_EN
   logic [2:0]  combo;
   assign pts = POINTS_PER_BRICK * (32'(combo) + 32'd1);
`else
   logic        unused_plate_hit;
   assign unused_plate_hit = plate_hit;
   assign pts = POINTS_PER_BRICK;
`endif

   // Direction bits are {up, down, left, right}; an underflow wraps to 5'h1f and falls out of range.
   assign tr = {1'b0, row_q} + {4'b0, dir_q[2]} - {4'b0, dir_q[3]};
   assign tc = {1'b0, col_q} + {4'b0, dir_q[0]} - {4'b0, dir_q[1]};

   assign brick_there = tgt_ok & bricks[tgt_idx];
   assign bricks_nx   = bricks & ~(56'd1 << tgt_idx);
   assign sum         = 32'(score) + pts;
   assign score_nx    = (sum > SCORE_MAX) ? 10'(SCORE_MAX) : sum[9:0];

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         bricks     <= '1;
         score      <= '0;
         lives      <= 2'(LIVES);
         hit        <= 1'b0;
         busy       <= 1'b0;
         IsGameOver <= 1'b0;
         IsWin      <= 1'b0;
         miss_pend  <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         dir_q      <= '0;
         tgt_idx    <= '0;
         tgt_ok     <= 1'b0;
`ifdef COMBO_BONUS_EN
         combo      <= '0;
`endif
      end else begin
         hit <= 1'b0;
         case (state)
            IDLE: begin
               if (miss || miss_pend) begin
                  miss_pend <= 1'b0;
                  lives     <= lives - 2'd1;
`ifdef COMBO_BONUS_EN
                  combo     <= '0;
`endif
                  if (lives == 2'd1) begin
                     IsGameOver <= 1'b1;
                     state      <= DONE;
                  end
               end else if (step) begin
                  row_q <= Ball_rowIndex;
                  col_q <= Ball_colIndex;
                  dir_q <= Ball_direction;
                  busy  <= 1'b1;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (miss) miss_pend <= 1'b1;
               tgt_idx <= {tr[2:0], tc[2:0]};
               tgt_ok  <= (tr <= 5'd6) && (tc <= 5'd7);
               state   <= UPDATE;
            end
            UPDATE: begin
               if (miss) miss_pend <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
               if (brick_there) begin
                  bricks <= bricks_nx;
                  score  <= score_nx;
                  hit    <= 1'b1;
`ifdef COMBO_BONUS_EN
                  if (combo != 3'd7) combo <= combo + 3'd1;
`endif
                  if (bricks_nx == '0) begin
                     IsWin <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            default: ;
         endcase
`ifdef COMBO_BONUS_EN
         // A plate bounce breaks the combo even if a hit lands in the same cycle.
         if (plate_hit && state != DONE) combo <= '0;
`endif
      end
   end

endmodule
